// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit feeder.
package uart_pkg;

  localparam int UART_DW        = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_AW_DEF    = 4;
  localparam int EN_HOLD_DEF    = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    ARM       = 3'd2,
    WAIT_DONE = 3'd3,
    WAIT_CLR  = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered occupancy flags.
// Writes into a full FIFO and reads from an empty FIFO are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = FIFO_AW_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               push,
  input  logic [UART_DW-1:0] wdata,
  input  logic               pop,
  output logic [UART_DW-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [UART_DW-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;
  logic [AW:0]        count_n;

  // qualify requests against the current flags and form the next occupancy
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    count_n = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  // storage array; contents need no reset since empty gates every read
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_n;
      full  <= (count_n == FULL_CNT);
      empty <= (count_n == '0);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue plus TxEn/TxDone handshake sequencer in front of a UART transmitter.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  IDLE      | nothing in flight; waits for the queue to hold a byte
//  LOAD      | pops the head byte onto TxData and raises TxEn
//  ARM       | holds TxEn high; hold counter counts down to zero
//  WAIT_DONE | TxEn low, TxData held; waits for the transmitter to raise TxDone
//  WAIT_CLR  | waits for TxDone to fall so the next TxEn edge is never masked
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH   = FIFO_DEPTH_DEF,
  parameter int AW      = FIFO_AW_DEF,
  parameter int EN_HOLD = EN_HOLD_DEF
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               WrEn,
  input  logic [UART_DW-1:0] WrData,
  output logic               Full,
  output logic               Empty,
  output logic [AW:0]        Count,
  output logic               Overflow,
  input  logic               OvfClr,
  output logic               TxEn,
  output logic [UART_DW-1:0] TxData,
  input  logic               TxDone,
  output logic               Busy
);

  localparam int          HW        = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(EN_HOLD - 1);

  feeder_state_t      state_q;
  feeder_state_t      state_n;
  logic [HW-1:0]      hold_q;
  logic [HW-1:0]      hold_n;
  logic               tx_en_n;
  logic [UART_DW-1:0] tx_data_n;
  logic               pop;
  logic [UART_DW-1:0] head;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (WrEn),
    .wdata (WrData),
    .pop   (pop),
    .rdata (head),
    .full  (Full),
    .empty (Empty),
    .count (Count)
  );

  // next-state and handshake outputs; LOAD is only entered with a non-empty queue
  always_comb begin
    state_n   = state_q;
    hold_n    = hold_q;
    tx_en_n   = TxEn;
    tx_data_n = TxData;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Empty) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        pop       = 1'b1;
        tx_data_n = head;
        tx_en_n   = 1'b1;
        hold_n    = HOLD_INIT;
        state_n   = ARM;
      end
      ARM: begin
        if (hold_q == '0) begin
          tx_en_n = 1'b0;
          state_n = WAIT_DONE;
        end else begin
          hold_n = hold_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        tx_en_n = 1'b0;
        if (TxDone) begin
          state_n = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        tx_en_n = 1'b0;
        if (!TxDone) begin
          state_n = IDLE;
        end
      end
      default: begin
        tx_en_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // FSM, hold counter and transmitter-facing registers; reset abandons any byte in flight
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      TxEn    <= 1'b0;
      TxData  <= '0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      TxEn    <= tx_en_n;
      TxData  <= tx_data_n;
    end
  end

  // sticky drop flag; a dropped write outranks a simultaneous clear
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Overflow <= 1'b0;
    end else if (WrEn && Full) begin
      Overflow <= 1'b1;
    end else if (OvfClr) begin
      Overflow <= 1'b0;
    end
  end

  assign Busy = (state_q != IDLE) | ~Empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against an edge-level reference model.
module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int EN_HOLD = 2;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          WrEn;
  logic [7:0]    WrData;
  logic          Full;
  logic          Empty;
  logic [AW:0]   Count;
  logic          Overflow;
  logic          OvfClr;
  logic          TxEn;
  logic [7:0]    TxData;
  logic          TxDone;
  logic          Busy;

  always #5 Clk = ~Clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .EN_HOLD(EN_HOLD)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .WrEn     (WrEn),
    .WrData   (WrData),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .Overflow (Overflow),
    .OvfClr   (OvfClr),
    .TxEn     (TxEn),
    .TxData   (TxData),
    .TxDone   (TxDone),
    .Busy     (Busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: pending bytes with the edge they were accepted on
  logic [7:0] q_data[$];
  int         q_edge[$];
  logic [7:0] sent[$];
  bit         m_free      = 1'b1;
  int         m_f         = 0;
  int         m_rise      = -100;
  bit         m_wait_high = 1'b0;
  logic [7:0] m_txdata    = 8'h00;
  bit         m_ovf       = 1'b0;

  // transmitter model
  bit g_active = 1'b0;
  int g_t      = 0;
  int g_delay  = 4;
  int g_len    = 2;
  bit stall    = 1'b0;
  int nd       = 4;
  int nl       = 2;

  // observations of the DUT
  logic [7:0] dut_sent[$];
  logic       prev_txen = 1'b0;
  bit         last_done = 1'b0;
  int         fall_cyc  = 0;
  int         dut_gap   = -1;

  typedef struct {
    bit         rst_n;
    bit         wr;
    logic [7:0] d;
    bit         done;
    bit         clr;
    bit         e_en;
    logic [7:0] e_data;
    int         e_count;
    bit         e_empty;
    bit         e_busy;
    bit         e_ovf;
  } vec_t;

  vec_t tv[$];

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_vec(input bit rst_n, input bit wr, input logic [7:0] d, input bit done,
                         input bit clr, input bit e_en, input logic [7:0] e_data,
                         input int e_count, input bit e_empty, input bit e_busy, input bit e_ovf);
    vec_t v;
    v.rst_n = rst_n; v.wr = wr; v.d = d; v.done = done; v.clr = clr;
    v.e_en = e_en; v.e_data = e_data; v.e_count = e_count;
    v.e_empty = e_empty; v.e_busy = e_busy; v.e_ovf = e_ovf;
    tv.push_back(v);
  endtask

  // advance the model by one clock edge with the inputs that edge sampled
  task automatic model_edge(input bit a_rst, input bit a_wr, input logic [7:0] a_d,
                            input bit a_clr, input bit a_done);
    bit full_before;
    if (!a_rst) begin
      q_data.delete();
      q_edge.delete();
      sent.delete();
      m_free      = 1'b1;
      m_f         = cyc;
      m_rise      = -100;
      m_wait_high = 1'b0;
      m_txdata    = 8'h00;
      m_ovf       = 1'b0;
      g_active    = 1'b0;
    end else begin
      full_before = (q_data.size() == DEPTH);
      if (!m_free) begin
        if (!m_wait_high) begin
          if (cyc > m_rise + EN_HOLD && a_done) m_wait_high = 1'b1;
        end else if (!a_done) begin
          m_free   = 1'b1;
          m_f      = cyc;
          g_active = 1'b0;
        end
      end else if (q_data.size() > 0 && cyc == imax(m_f, q_edge[0]) + 2) begin
        m_txdata = q_data.pop_front();
        void'(q_edge.pop_front());
        sent.push_back(m_txdata);
        m_free      = 1'b0;
        m_rise      = cyc;
        m_wait_high = 1'b0;
        g_active    = 1'b1;
        g_t         = 0;
        g_delay     = nd;
        g_len       = nl;
      end
      if (a_wr && !full_before) begin
        q_data.push_back(a_d);
        q_edge.push_back(cyc);
      end
      if (a_wr && full_before) m_ovf = 1'b1;
      else if (a_clr)          m_ovf = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    int n;
    n = q_data.size();
    check("count",    Count,    n);
    check("empty",    Empty,    n == 0);
    check("full",     Full,     n == DEPTH);
    check("tx_en",    TxEn,     (cyc >= m_rise) && (cyc < m_rise + EN_HOLD));
    check("tx_data",  TxData,   m_txdata);
    check("busy",     Busy,     (n > 0) || !m_free);
    check("overflow", Overflow, m_ovf);
  endtask

  task automatic step(input bit run, input bit wr, input logic [7:0] d, input bit clr);
    bit done_i;
    done_i = g_active && !stall && (g_t >= g_delay) && (g_t < g_delay + g_len);
    Rst_n  = run;
    WrEn   = wr;
    WrData = d;
    OvfClr = clr;
    TxDone = done_i;
    @(posedge Clk);
    cyc++;
    if (last_done && !done_i) fall_cyc = cyc;
    last_done = done_i;
    model_edge(run, wr, d, clr, done_i);
    #1;
    if (!run) dut_sent.delete();
    if (TxEn && !prev_txen) begin
      dut_sent.push_back(TxData);
      dut_gap = cyc - fall_cyc;
    end
    prev_txen = TxEn;
    compare_outputs();
    if (g_active && !stall) g_t++;
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while (!(m_free && q_data.size() == 0) && k < max_cyc) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      k++;
    end
    check("drain_done_in_budget", (m_free && q_data.size() == 0), 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int w;
    int k;

    // reset with a write pending, then one byte through a slow transmitter
    add_vec(0, 1, 8'hA5, 0, 0,  0, 8'h00, 0, 1, 0, 0);
    add_vec(0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 1, 0, 0);
    add_vec(1, 1, 8'h3C, 0, 0,  0, 8'h00, 1, 0, 1, 0);
    add_vec(1, 0, 8'h00, 0, 0,  0, 8'h00, 1, 0, 1, 0);
    add_vec(1, 0, 8'h00, 0, 0,  1, 8'h3C, 0, 1, 1, 0);
    add_vec(1, 0, 8'h00, 1, 0,  1, 8'h3C, 0, 1, 1, 0);
    add_vec(1, 0, 8'h00, 1, 0,  0, 8'h3C, 0, 1, 1, 0);
    for (int i = 0; i < 7; i++) add_vec(1, 0, 8'h00, 0, 0,  0, 8'h3C, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) add_vec(1, 0, 8'h00, 1, 0,  0, 8'h3C, 0, 1, 1, 0);
    add_vec(1, 0, 8'h00, 0, 0,  0, 8'h3C, 0, 1, 0, 0);
    add_vec(1, 0, 8'h00, 1, 0,  0, 8'h3C, 0, 1, 0, 0);
    add_vec(1, 0, 8'h00, 0, 1,  0, 8'h3C, 0, 1, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      Rst_n = tv[i].rst_n; WrEn = tv[i].wr; WrData = tv[i].d;
      TxDone = tv[i].done; OvfClr = tv[i].clr;
      @(posedge Clk);
      cyc++;
      #1;
      check($sformatf("vec%0d_tx_en", i),    TxEn,     tv[i].e_en);
      check($sformatf("vec%0d_tx_data", i),  TxData,   tv[i].e_data);
      check($sformatf("vec%0d_count", i),    Count,    tv[i].e_count);
      check($sformatf("vec%0d_empty", i),    Empty,    tv[i].e_empty);
      check($sformatf("vec%0d_busy", i),     Busy,     tv[i].e_busy);
      check($sformatf("vec%0d_overflow", i), Overflow, tv[i].e_ovf);
    end

    // fill while the FSM is parked on a byte, then overflow and clear
    step(1'b0, 1'b0, 8'h00, 1'b0);
    stall = 1'b1; nd = 4; nl = 2;
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
    check("t3_full", Full, 1);
    check("t3_count16", Count, 16);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    check("t3_overflow_set", Overflow, 1);
    check("t3_count_after_drop", Count, 16);
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
    check("t3_overflow_sticky", Overflow, 1);
    step(1'b1, 1'b1, 8'hFE, 1'b1);
    check("t3_set_beats_clear", Overflow, 1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    check("t3_overflow_cleared", Overflow, 0);
    stall = 1'b0;
    drain(800);
    check("t3_stream_len", dut_sent.size(), 17);
    if (dut_sent.size() == 17) begin
      check("t3_first_byte", dut_sent[0], 8'hEE);
      for (int i = 0; i < 16; i++) check("t3_order", dut_sent[i+1], i);
    end

    // long TxDone high: next TxEn edge only two edges after TxDone falls
    step(1'b0, 1'b0, 8'h00, 1'b0);
    nd = 4; nl = 20;
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    step(1'b1, 1'b1, 8'h6B, 1'b0);
    drain(300);
    check("t4_stream_len", dut_sent.size(), 2);
    check("t4_rise_after_fall", dut_gap, 2);

    // simultaneous write and pop at Count=5, then wrap the pointers
    step(1'b0, 1'b0, 8'h00, 1'b0);
    stall = 1'b1; nd = 3; nl = 1;
    step(1'b1, 1'b1, 8'h10, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
    check("t5_count5", Count, 5);
    stall = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 100 && !found; j++) begin
      if (m_free && q_data.size() > 0 && (cyc + 1 == imax(m_f, q_edge[0]) + 2)) found = 1'b1;
      else step(1'b1, 1'b0, 8'h00, 1'b0);
    end
    check("t5_pop_edge_reached", found, 1);
    if (found) begin
      step(1'b1, 1'b1, 8'h16, 1'b0);
      check("t5_count_hold", Count, 5);
    end
    w = 0; k = 0;
    while (w < 40 && k < 3000) begin
      if (q_data.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        step(1'b1, 1'b1, 8'(8'h80 + w), 1'b0);
        w++;
      end else begin
        step(1'b1, 1'b0, 8'h00, 1'b0);
      end
      k++;
    end
    drain(1000);
    check("t5_stream_len", dut_sent.size(), 47);
    if (dut_sent.size() == 47) begin
      for (int i = 0; i < 7; i++) check("t5_head_order", dut_sent[i], 8'h10 + i);
      for (int i = 0; i < 40; i++) check("t5_wrap_order", dut_sent[i+7], 8'h80 + i);
    end

    // reset while waiting for TxDone with bytes queued
    step(1'b0, 1'b0, 8'h00, 1'b0);
    stall = 1'b1; nd = 3; nl = 2;
    step(1'b1, 1'b1, 8'h77, 1'b0);
    repeat (5) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'hA1 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("t6_empty", Empty, 1);
    check("t6_tx_en", TxEn, 0);
    check("t6_busy", Busy, 0);
    check("t6_count", Count, 0);
    stall = 1'b0;
    repeat (12) step(1'b1, 1'b0, 8'h00, 1'b0);
    check("t6_no_emit", dut_sent.size(), 0);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    drain(100);
    check("t6_new_len", dut_sent.size(), 1);
    if (dut_sent.size() == 1) check("t6_new_byte", dut_sent[0], 8'h99);

    // randomized traffic with bursty phases and occasional reset
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      bit wr;
      bit clr;
      bit run;
      int pct;
      pct = (((i / 250) % 2) == 0) ? 70 : 15;
      wr  = ($urandom_range(0, 99) < pct);
      clr = ($urandom_range(0, 39) == 0);
      run = ($urandom_range(0, 599) != 0);
      nd  = $urandom_range(3, 8);
      nl  = $urandom_range(1, 4);
      step(run, wr, 8'($urandom), clr);
    end
    drain(600);
    check("rnd_stream_len", dut_sent.size(), sent.size());
    for (int i = 0; i < dut_sent.size() && i < sent.size(); i++)
      check("rnd_stream_byte", dut_sent[i], sent[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
